// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: ALU op codes, sizing
// constants and the registered output bundle handed to the ALU.
package operand_fetch_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int DATA_W   = 8;
  localparam int OP_W     = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_LSL  = 5'd5,
    OP_LSR  = 5'd6,
    OP_PASS = 5'd7
  } op_code;

  typedef struct packed {
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    op_code            OP;
    logic              Wr;
    logic [REG_AW-1:0] Rd;
  } fetch_out_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, writeback and ALU-side handshake signals of the operand-fetch stage.
interface operand_fetch_if #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int OPW  = 5
);
  localparam int AW = $clog2(NREG);

  logic           InValid;
  logic           InReady;
  logic [OPW-1:0] InOP;
  logic [AW-1:0]  InRa;
  logic [AW-1:0]  InRb;
  logic           InUseImm;
  logic [DW-1:0]  InImm;
  logic           InWr;
  logic [AW-1:0]  InRd;
  logic           WrEn;
  logic [AW-1:0]  WrAddr;
  logic [DW-1:0]  WrData;
  logic           OutValid;
  logic           OutReady;
  logic [DW-1:0]  OutA;
  logic [DW-1:0]  OutB;
  logic [OPW-1:0] OutOP;
  logic           OutWr;
  logic [AW-1:0]  OutRd;

  modport master (
    output InValid, InOP, InRa, InRb, InUseImm, InImm, InWr, InRd,
    output WrEn, WrAddr, WrData, OutReady,
    input  InReady, OutValid, OutA, OutB, OutOP, OutWr, OutRd
  );

  modport slave (
    input  InValid, InOP, InRa, InRb, InUseImm, InImm, InWr, InRd,
    input  WrEn, WrAddr, WrData, OutReady,
    output InReady, OutValid, OutA, OutB, OutOP, OutWr, OutRd
  );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// NREG x DW architectural register file: two combinational read ports with
// same-cycle write bypass, one write port, asynchronous active-low clear.
module reg_file #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata_a = (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
    rdata_b = (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch pipeline stage: reads two operands (or an immediate for B),
// stalls on RAW hazards tracked by a pending-bit scoreboard, registers to ALU.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DW   = DATA_W,
  parameter int NREG = NUM_REGS,
  parameter int OPW  = OP_W
) (
  input  logic           Clk,
  input  logic           Reset,
  operand_fetch_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0]   opnd_a;
  logic [DW-1:0]   opnd_b;
  logic            hazard;
  logic            in_ready;
  logic            accept;
  logic            hit_a;
  logic            hit_b;
  fetch_out_t      out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [NREG-1:0] pend_q, pend_d;

  reg_file #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_reg_file (
    .Clk     (Clk),
    .Reset   (Reset),
    .we      (bus.WrEn),
    .waddr   (bus.WrAddr),
    .wdata   (bus.WrData),
    .raddr_a (bus.InRa),
    .raddr_b (bus.InRb),
    .rdata_a (opnd_a),
    .rdata_b (opnd_b)
  );

  // A producer retiring this very cycle is not a hazard: the bypass supplies it.
  always_comb begin
    hit_a    = pend_q[bus.InRa] && !(bus.WrEn && bus.WrAddr == bus.InRa);
    hit_b    = !bus.InUseImm && pend_q[bus.InRb] && !(bus.WrEn && bus.WrAddr == bus.InRb);
    hazard   = bus.InValid && (hit_a || hit_b);
    in_ready = (!out_valid_q || bus.OutReady) && !hazard;
    accept   = bus.InValid && in_ready;
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d.A     = opnd_a;
      out_d.B     = bus.InUseImm ? bus.InImm : opnd_b;
      out_d.OP    = op_code'(bus.InOP[OPW-1:0]);
      out_d.Wr    = bus.InWr;
      out_d.Rd    = bus.InRd;
      out_valid_d = 1'b1;
    end else if (bus.OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Set after clear so a new producer to the same index stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (bus.WrEn) pend_d[bus.WrAddr] = 1'b0;
    if (accept && bus.InWr) pend_d[bus.InRd] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid_q;
  assign bus.OutA     = out_q.A;
  assign bus.OutB     = out_q.B;
  assign bus.OutOP    = out_q.OP;
  assign bus.OutWr    = out_q.Wr;
  assign bus.OutRd    = out_q.Rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios then random traffic,
// checked against a register-array / pending-set reference model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] op;
    logic       wr;
    logic [2:0] rd;
  } exp_t;

  logic Clk;
  logic Reset;
  int   compared   = 0;
  int   mismatched = 0;

  exp_t       exp_q[$];
  logic [2:0] retire_q[$];
  logic [7:0] m_rf [8];
  logic [7:0] m_pend;

  operand_fetch_if #(.DW(8), .NREG(8), .OPW(5)) bus ();

  operand_fetch #(.DW(8), .NREG(8), .OPW(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the set of registers whose
  // producer has issued but not yet written back; expected outputs queue up.
  logic       m_valid, m_hz, m_rdy, m_acc;
  exp_t       e, head;
  always @(negedge Clk) begin
    if (!Reset) begin
      exp_q.delete();
      m_pend = '0;
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    end else begin
      m_valid = (exp_q.size() != 0);
      check("out_valid", bus.OutValid, m_valid);
      if (m_valid && bus.OutValid) begin
        head = exp_q[0];
        check("out_a",  bus.OutA,  head.a);
        check("out_b",  bus.OutB,  head.b);
        check("out_op", bus.OutOP, head.op);
        check("out_wr", bus.OutWr, head.wr);
        check("out_rd", bus.OutRd, head.rd);
      end
      m_hz = bus.InValid &&
             ((m_pend[bus.InRa] && !(bus.WrEn && bus.WrAddr == bus.InRa)) ||
              (!bus.InUseImm && m_pend[bus.InRb] && !(bus.WrEn && bus.WrAddr == bus.InRb)));
      m_rdy = (!m_valid || bus.OutReady) && !m_hz;
      check("in_ready", bus.InReady, m_rdy);
      if (m_valid && bus.OutReady) begin
        e = exp_q.pop_front();
        if (e.wr) retire_q.push_back(e.rd);
      end
      m_acc = bus.InValid && m_rdy;
      if (m_acc) begin
        e.a  = (bus.WrEn && bus.WrAddr == bus.InRa) ? bus.WrData : m_rf[bus.InRa];
        e.b  = bus.InUseImm ? bus.InImm :
               ((bus.WrEn && bus.WrAddr == bus.InRb) ? bus.WrData : m_rf[bus.InRb]);
        e.op = bus.InOP;
        e.wr = bus.InWr;
        e.rd = bus.InRd;
        exp_q.push_back(e);
      end
      if (bus.WrEn) begin
        m_rf[bus.WrAddr]   = bus.WrData;
        m_pend[bus.WrAddr] = 1'b0;
      end
      if (m_acc && bus.InWr) m_pend[bus.InRd] = 1'b1;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.InValid = 0; bus.InOP = 5'd0; bus.InRa = 3'd0; bus.InRb = 3'd0;
    bus.InUseImm = 0; bus.InImm = 8'h00; bus.InWr = 0; bus.InRd = 3'd0;
    bus.WrEn = 0; bus.WrAddr = 3'd0; bus.WrData = 8'h00; bus.OutReady = 1;
  endtask

  task automatic present(input logic [4:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic use_imm, input logic [7:0] imm,
                         input logic wr, input logic [2:0] rd);
    bus.InValid = 1; bus.InOP = op; bus.InRa = ra; bus.InRb = rb;
    bus.InUseImm = use_imm; bus.InImm = imm; bus.InWr = wr; bus.InRd = rd;
  endtask

  logic [7:0] hold_a, hold_b;
  logic [4:0] hold_op;
  logic       acc;
  int         stall;

  initial begin
    // Reset with random inputs applied.
    Reset = 0;
    for (int i = 0; i < 4; i++) begin
      bus.InValid = 1'($urandom); bus.InOP = 5'($urandom); bus.InRa = 3'($urandom);
      bus.InRb = 3'($urandom); bus.InUseImm = 1'($urandom); bus.InImm = 8'($urandom);
      bus.InWr = 1'($urandom); bus.InRd = 3'($urandom); bus.WrEn = 1'($urandom);
      bus.WrAddr = 3'($urandom); bus.WrData = 8'($urandom); bus.OutReady = 1'($urandom);
      step();
    end
    idle();
    Reset = 1;
    #1;
    check("rst_out_valid", bus.OutValid, 1'b0);
    check("rst_in_ready", bus.InReady, 1'b1);
    for (int i = 0; i < 8; i++) begin
      present(OP_PASS, 3'(i), 3'(7 - i), 1'b0, 8'h00, 1'b0, 3'd0);
      step();
      check("rst_reg_read", bus.OutA, 8'h00);
    end
    idle();
    step();

    // Basic issue.
    bus.WrEn = 1; bus.WrAddr = 3'd1; bus.WrData = 8'h05; step();
    bus.WrAddr = 3'd2; bus.WrData = 8'h03; step();
    bus.WrEn = 0;
    bus.OutReady = 0;
    present(OP_ADD, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1, 3'd3);
    step();
    bus.InValid = 0;
    check("basic_a",  bus.OutA,  8'h05);
    check("basic_b",  bus.OutB,  8'h03);
    check("basic_op", bus.OutOP, OP_ADD);
    check("basic_rd", bus.OutRd, 3'd3);
    check("basic_valid", bus.OutValid, 1'b1);
    bus.OutReady = 1;
    step();
    retire_q.delete();

    // RAW stall on r3, released by same-cycle writeback bypass.
    present(OP_SUB, 3'd3, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1 check("raw_stall", bus.InReady, 1'b0);
      step();
    end
    bus.WrEn = 1; bus.WrAddr = 3'd3; bus.WrData = 8'h08;
    #1 check("raw_bypass_ready", bus.InReady, 1'b1);
    step();
    bus.WrEn = 0; bus.InValid = 0;
    check("raw_bypass_a", bus.OutA, 8'h08);
    present(OP_SUB, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0);
    #1 check("raw_pend_cleared", bus.InReady, 1'b1);
    step();

    // Immediate bypasses a pending Rb.
    present(OP_PASS, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd2);
    step();
    present(OP_LSL, 3'd1, 3'd2, 1'b1, 8'h02, 1'b0, 3'd0);
    #1 check("imm_ready", bus.InReady, 1'b1);
    step();
    bus.InValid = 0;
    check("imm_a", bus.OutA, 8'h05);
    check("imm_b", bus.OutB, 8'h02);
    check("imm_op", bus.OutOP, OP_LSL);

    // Backpressure holds the LSL output.
    bus.OutReady = 0;
    present(OP_AND, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", bus.InReady, 1'b0);
      step();
      check("bp_hold_a", bus.OutA, 8'h05);
      check("bp_hold_b", bus.OutB, 8'h02);
      check("bp_hold_op", bus.OutOP, OP_LSL);
    end
    bus.OutReady = 1;
    #1 check("bp_release_ready", bus.InReady, 1'b1);
    step();
    bus.InValid = 0;
    check("bp_next_b", bus.OutB, 8'h05);
    check("bp_next_op", bus.OutOP, OP_AND);
    step();
    check("bp_single_accept", bus.OutValid, 1'b0);

    // Reset mid-operation.
    bus.OutReady = 0;
    present(OP_ADD, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd3);
    step();
    bus.InValid = 0;
    check("mid_valid_before", bus.OutValid, 1'b1);
    Reset = 0;
    #1 check("mid_valid_cleared", bus.OutValid, 1'b0);
    step();
    Reset = 1;
    retire_q.delete();
    bus.OutReady = 1;
    present(OP_OR, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0);
    #1 check("mid_no_stall", bus.InReady, 1'b1);
    step();
    bus.InValid = 0;
    check("mid_reg_cleared", bus.OutA, 8'h00);
    step();

    // Random traffic with a modelled writeback stream.
    acc = 0;
    stall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!bus.InValid || acc) begin
        if ($urandom_range(0, 9) < 7)
          present(5'($urandom), 3'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0),
                  8'($urandom), ($urandom_range(0, 9) < 7), 3'($urandom));
        else
          bus.InValid = 0;
      end
      bus.WrEn = 0;
      if (retire_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        bus.WrEn = 1; bus.WrAddr = retire_q.pop_front(); bus.WrData = 8'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.WrAddr = 3'($urandom);
        bus.WrData = 8'($urandom);
        bus.WrEn   = !m_pend[bus.WrAddr];
      end
      bus.OutReady = ($urandom_range(0, 3) != 0);
      @(negedge Clk);
      acc = bus.InValid && bus.InReady;
      stall = (bus.InValid && !acc) ? stall + 1 : 0;
      if (stall > 300) begin
        compared++;
        mismatched++;
        $display("FAIL stall_bound: stalled %0d cycles, limit 300", stall);
        break;
      end
      @(posedge Clk);
      #1;
    end
    idle();
    step(); step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Single-entry pipeline stage directly upstream of the ALU.
- Holds the 8x8 architectural register file and reads two source operands, with an optional immediate replacing operand B.
- Registers OutA, OutB and OutOP, which drive the ALU's InA, InB and OP inputs, under a valid/ready handshake.
- Tracks pending destination registers in a scoreboard and stalls on read-after-write hazards until the writeback port retires the producer.

Parameters:
- DW, 8, datapath width (ALU operand width).
- NREG, 8, number of architectural registers.
- OPW, 5, op-code width (matches the ALU OP port).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InValid  in  1  upstream decoded instruction valid.
- InReady  out  1  stage can accept this cycle.
- InOP  in  OPW  ALU op code (op_code encoding).
- InRa  in  $clog2(NREG)  source A register index.
- InRb  in  $clog2(NREG)  source B register index.
- InUseImm  in  1  1 = B operand from InImm, Rb ignored.
- InImm  in  DW  immediate operand.
- InWr  in  1  instruction writes a destination register.
- InRd  in  $clog2(NREG)  destination register index.
- WrEn  in  1  writeback strobe.
- WrAddr  in  $clog2(NREG)  writeback register index.
- WrData  in  DW  writeback data (ALU Out after the downstream stage).
- OutValid  out  1  OutA/OutB/OutOP valid.
- OutReady  in  1  downstream consumes this cycle.
- OutA  out  DW  registered operand A to the ALU.
- OutB  out  DW  registered operand B to the ALU.
- OutOP  out  OPW  registered op code to the ALU.
- OutWr  out  1  carried InWr.
- OutRd  out  $clog2(NREG)  carried InRd.

Behaviour:
- Reset asserted (Reset=0), asynchronous:
  - all registers, OutA, OutB, OutOP, OutRd and OutWr clear to 0;
  - OutValid=0 and the scoreboard is cleared.
  - Reset asserted mid-operation discards the held instruction and all pending bits.
- Register-file read: combinational, with same-cycle write bypass.
  - If WrEn && WrAddr==InRa, operand A = WrData; likewise for Rb.
  - Register 0 is an ordinary register, not hardwired.
- Register-file write: on the rising edge when WrEn=1.
- Scoreboard: pend[NREG] bits.
  - Hazard = InValid && ((pend[InRa] && !(WrEn && WrAddr==InRa)) || (!InUseImm && pend[InRb] && !(WrEn && WrAddr==InRb))).
- Ready and accept:
  - InReady = (!OutValid || OutReady) && !hazard. InReady is combinational; it may depend on InValid only through hazard.
  - Accept = InValid && InReady. On accept, the output register loads {operand A, InUseImm ? InImm : operand B, InOP, InWr, InRd} and OutValid=1.
- Output hold:
  - If OutReady and no accept, OutValid goes to 0.
  - If OutValid && !OutReady, all Out* signals hold stable (no change while stalled).
  - Latency: accept at edge N gives OutValid at N, so operands are visible one cycle after presentation. Back-to-back throughput is 1 per cycle when there is no hazard.
- Scoreboard update per edge:
  - WrEn clears pend[WrAddr].
  - Accept with InWr sets pend[InRd].
  - If both hit the same index in the same cycle, set wins (the new producer is outstanding).
- An instruction whose Rd equals its own Ra/Rb reads the old value; its pend bit is set only after issue.
- WrEn to a non-pending register is a legal architectural write; the scoreboard is unaffected.
- Arithmetic: no arithmetic in this block; widths pass through unchanged.

Decomposition:
- Shared package Definitions, alongside op_code:
  - constants NUM_REGS=8 and REG_AW=3;
  - struct fetch_out_t {A, B, op_code OP, Wr, Rd}. The output register is one instance of this struct.
- Natural sub-module: reg_file.
  - NREG x DW storage with async active-low clear, two combinational read ports with write bypass, and one write port.
  - operand_fetch instantiates it and adds the scoreboard and handshake.

Test Plan:
- Reset: hold Reset=0 with random inputs, then release. Required: OutValid=0, InReady=1, and reading r0..r7 returns 0x00.
- Basic issue: write r1=0x05 and r2=0x03 via WrEn. Then present InOP=ADD, Ra=1, Rb=2, InWr=1, Rd=3. Required: the next edge gives OutA=0x05, OutB=0x03, OutOP=ADD, OutRd=3, OutValid=1.
- RAW stall: with r3 pending from the previous instruction, present Ra=3.
  - Required: InReady=0 while WrEn is absent.
  - Then drive WrEn, WrAddr=3, WrData=0x08. Required: same-cycle accept with OutA=0x08 via bypass, and pend[3] cleared.
- Immediate: InUseImm=1, InImm=0x02, InOP=LSL, Ra=1 (0x05), with r2 pending. Required: no stall, OutB=0x02, OutA=0x05.
- Backpressure: OutReady=0 for 3 cycles while holding a valid output. Required: Out* stable, InReady=0, and exactly one accept after OutReady=1.
- Reset mid-op: assert Reset while OutValid=1 and pend[3]=1. Required: OutValid=0 immediately, and after release Ra=3 issues without stall.
